// File: rtl/dmem_mmio_responder_pkg.sv
// dmem_mmio_pkg
//   Shared constants for the data-memory responder: MMIO word offsets,
//   TX_STATUS bit layout and the default MMIO base word address.
package dmem_mmio_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;
    localparam int          MMIO_WORDS        = 8;

    localparam logic [2:0] OFF_CYCLE     = 3'd0;
    localparam logic [2:0] OFF_LED       = 3'd1;
    localparam logic [2:0] OFF_TX_DATA   = 3'd2;
    localparam logic [2:0] OFF_TX_STATUS = 3'd3;
    localparam logic [2:0] OFF_TX_DROPS  = 3'd4;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 4;

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// tx_fifo
//   Synchronous FIFO. A push while full is accepted only when a pop happens
//   in the same cycle (the freed slot is reused, count unchanged).
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   push, push_data   write request and byte
//   pop               read request (ignored when empty)
//   head              oldest entry
//   full, empty       occupancy flags
//   count             occupancy 0..DEPTH
module tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Data-memory port responder. Decodes each word address into external RAM,
//   an 8-word MMIO block (cycle counter, LED, TX FIFO, drop counter) or
//   unmapped space. Load data is registered: q_dmem in cycle N+1 answers
//   the address of cycle N.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   address_dmem, data, wren      processor word address, store data, store strobe
//   q_dmem                        load data
//   ram_addr, ram_wdata, ram_wren external RAM request
//   ram_q                         RAM read data (one cycle after ram_addr)
//   led                           LED register
//   tx_valid, tx_data, tx_ready   TX FIFO drain handshake
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter  int          RAM_WORDS  = 4096,
    parameter  logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
    parameter  int          FIFO_DEPTH = 8,
    localparam int          RAM_AW     = $clog2(RAM_WORDS),
    localparam int          FIFO_CW    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    output logic [31:0]       q_dmem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    output logic [15:0]       led,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    logic [31:0]        mmio_off_full;
    logic [2:0]         mmio_off;
    logic               is_ram;
    logic               is_mmio;
    logic               wr_led;
    logic               wr_tx;
    logic               wr_drops;
    logic               tx_pop;
    logic               tx_drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_CW-1:0] fifo_count;
    logic [31:0]        tx_status;
    logic [31:0]        mmio_rdata;
    logic [31:0]        cycle_cnt;
    logic [31:0]        tx_drops;
    logic               rd_is_ram;
    logic [31:0]        rd_data;

    // RAM takes priority should the MMIO window ever be placed inside it.
    assign mmio_off_full = address_dmem - MMIO_BASE;
    assign mmio_off      = mmio_off_full[2:0];
    assign is_ram        = (address_dmem < 32'(RAM_WORDS));
    assign is_mmio       = !is_ram && (mmio_off_full < 32'(MMIO_WORDS));

    assign ram_addr  = address_dmem[RAM_AW-1:0];
    assign ram_wdata = data;
    assign ram_wren  = wren && is_ram;

    assign wr_led   = wren && is_mmio && (mmio_off == OFF_LED);
    assign wr_tx    = wren && is_mmio && (mmio_off == OFF_TX_DATA);
    assign wr_drops = wren && is_mmio && (mmio_off == OFF_TX_DROPS);

    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;
    // A pop in the same cycle frees a slot, so only a full FIFO with no pop drops.
    assign tx_drop  = wr_tx && fifo_full && !tx_pop;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_tx),
        .push_data (data[7:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        tx_status                                      = '0;
        tx_status[STAT_FULL_BIT]                       = fifo_full;
        tx_status[STAT_EMPTY_BIT]                      = fifo_empty;
        tx_status[STAT_COUNT_LSB +: STAT_COUNT_W]      = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            OFF_CYCLE:     mmio_rdata = cycle_cnt;
            OFF_LED:       mmio_rdata = {16'h0000, led};
            OFF_TX_STATUS: mmio_rdata = tx_status;
            OFF_TX_DROPS:  mmio_rdata = tx_drops;
            default:       mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            led       <= '0;
            tx_drops  <= '0;
            rd_is_ram <= 1'b0;
            rd_data   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_led) begin
                led <= data[15:0];
            end
            if (wr_drops) begin
                tx_drops <= '0;
            end else if (tx_drop && (tx_drops != 32'hFFFF_FFFF)) begin
                tx_drops <= tx_drops + 32'd1;
            end
            rd_is_ram <= is_ram;
            rd_data   <= is_mmio ? mmio_rdata : 32'h0000_0000;
        end
    end

    // RAM data is already registered inside the RAM; only the region flag is ours.
    assign q_dmem = rd_is_ram ? ram_q : rd_data;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    localparam int          RAM_WORDS = 4096;
    localparam logic [31:0] MMIO      = 32'hFFFF_0000;
    localparam logic [31:0] IDLE_ADDR = 32'h4000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [15:0] led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .led          (led),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External synchronous RAM, read-before-write.
    logic [31:0] ram_mem [RAM_WORDS];
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
        ram_q <= ram_mem[ram_addr];
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  fifo_m[$];
    logic [15:0] led_m;
    logic [31:0] drops_m;
    logic [31:0] cyc_m;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check combinational outputs against the model,
    // advance the model, clock, then compare any pending load result.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
        logic was_full;
        logic pop;
        exp_t e;
        address_dmem = a;
        data         = d;
        wren         = w;
        #1;
        chk("ram_wren", {31'b0, ram_wren}, {31'b0, w && (a < RAM_WORDS)});
        if (w && (a < RAM_WORDS)) chk("ram_addr", 32'(ram_addr), a & 32'hFFF);
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, fifo_m.size() > 0});
        if (fifo_m.size() > 0) chk("tx_data", 32'(tx_data), 32'(fifo_m[0]));
        chk("led", 32'(led), 32'(led_m));

        was_full = (fifo_m.size() == 8);
        pop      = (fifo_m.size() > 0) && tx_ready;
        if (pop) void'(fifo_m.pop_front());
        if (w && a == MMIO + 1) led_m = d[15:0];
        if (w && a == MMIO + 2) begin
            if (!was_full || pop) fifo_m.push_back(d[7:0]);
            else if (drops_m != 32'hFFFF_FFFF) drops_m++;
        end
        if (w && a == MMIO + 4) drops_m = 0;

        @(posedge clock);
        #1;
        cyc_m++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, q_dmem, e.val);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        sb_q.push_back(e);
        bus(a, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(a, d, 1'b1);
    endtask

    // Reset for one cycle with a RAM load presented, so a result is in flight.
    task automatic do_reset();
        reset        = 1'b1;
        address_dmem = 32'd5;
        data         = 32'h0;
        wren         = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_q_dmem", q_dmem, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        fifo_m.delete();
        sb_q.delete();
        led_m   = '0;
        drops_m = '0;
        cyc_m   = '0;
        reset   = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        reset        = 1'b0;
        address_dmem = IDLE_ADDR;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        led_m        = '0;
        drops_m      = '0;
        cyc_m        = '0;

        do_reset();
        rd(MMIO + 0, cyc_m, "cycle_a");
        rd(MMIO + 0, cyc_m, "cycle_b");

        wr(MMIO + 1, 32'h0001_ABCD);
        rd(MMIO + 1, 32'h0000_ABCD, "led_rd");
        chk("led_val", 32'(led), 32'h0000_ABCD);

        wr(32'd5, 32'hDEAD_BEEF);
        rd(32'd5, 32'hDEAD_BEEF, "ram5");
        wr(32'd4095, 32'h1234_5678);
        rd(32'd4095, 32'h1234_5678, "ram_top");

        wr(32'h8000_0000, 32'hFFFF_FFFF);
        rd(32'h8000_0000, 32'h0, "unmapped");
        wr(MMIO + 5, 32'h1111_1111);
        rd(MMIO + 5, 32'h0, "reserved");
        wr(MMIO + 0, 32'h5555_5555);
        rd(MMIO + 0, cyc_m, "cycle_ro");
        rd(MMIO + 3, 32'h0000_0002, "status_empty0");

        for (int i = 0; i < 10; i++) wr(MMIO + 2, 32'h0000_00A0 + 32'(i));
        rd(MMIO + 2, 32'h0, "txdata_rd");
        rd(MMIO + 3, 32'h0000_0081, "status_full");
        rd(MMIO + 4, 32'd2, "drops2");

        tx_ready = 1'b1;
        wr(MMIO + 2, 32'h0000_0055);
        tx_ready = 1'b0;
        rd(MMIO + 3, 32'h0000_0081, "status_still_full");
        rd(MMIO + 4, 32'd2, "drops_kept");

        wr(MMIO + 4, 32'h0);
        rd(MMIO + 4, 32'd0, "drops_clr");

        tx_ready = 1'b1;
        for (int i = 0; i < 20 && fifo_m.size() > 0; i++) bus(IDLE_ADDR, 32'h0, 1'b0);
        chk("drain_done", 32'(fifo_m.size()), 32'd0);
        tx_ready = 1'b0;
        rd(MMIO + 3, 32'h0000_0002, "status_drained");

        for (int i = 0; i < 3; i++) wr(MMIO + 2, 32'h0000_00C0 + 32'(i));
        rd(MMIO + 3, 32'h0000_0030, "status_3");

        do_reset();
        rd(32'h8000_0000, 32'h0, "unmapped_rst");
        rd(32'd5, 32'hDEAD_BEEF, "ram_kept");
        rd(MMIO + 3, 32'h0000_0002, "status_rst");
        rd(MMIO + 0, cyc_m, "cycle_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder for the processor's data-memory port: it receives `address_dmem`, `data` and `wren`, and returns `q_dmem`. It decodes each word address into one of three targets: the external synchronous data RAM, a small block of memory-mapped I/O registers, or unmapped space. The MMIO block holds a free-running cycle counter, an LED register, and a byte-wide transmit FIFO with a valid/ready drain port. The block sits between the pipeline's memory stage and the RAM and peripherals, in place of a direct processor-to-RAM connection.

## Interface
Parameters:
- `RAM_WORDS`, 4096: number of 32-bit words in the external RAM; a power of two.
- `MMIO_BASE`, 32'hFFFF_0000: word address of the first MMIO register.
- `FIFO_DEPTH`, 8: TX FIFO entries; a power of two, at most 15.

Ports:
- `clock`  in  1: the single clock; everything is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `address_dmem`  in  32: word address from the processor.
- `data`  in  32: store data.
- `wren`  in  1: store strobe for the current address.
- `q_dmem`  out  32: load data, registered (see Timing).
- `ram_addr`  out  log2(RAM_WORDS): RAM word address, combinational from `address_dmem`.
- `ram_wdata`  out  32: equals `data`.
- `ram_wren`  out  1: `wren` gated by the RAM-region decode.
- `ram_q`  in  32: RAM read data, valid one cycle after `ram_addr`.
- `led`  out  16: LED register.
- `tx_valid`  out  1: FIFO not empty.
- `tx_data`  out  8: FIFO head byte.
- `tx_ready`  in  1: downstream accepts the head byte.

## Operation
- Address decode:
  - RAM: `address_dmem < RAM_WORDS`.
  - MMIO: `address_dmem - MMIO_BASE` lies in 0..7.
  - Otherwise unmapped: reads return 0 and writes are ignored.
- MMIO map (word offset from `MMIO_BASE`):
  - 0 CYCLE (RO): 32-bit counter, increments every cycle, wraps at 2^32.
  - 1 LED (RW): a write stores `data[15:0]`; a read returns the value zero-extended to 32 bits.
  - 2 TX_DATA (WO): a write pushes `data[7:0]`; a read returns 0.
  - 3 TX_STATUS (RO): bit0 = full, bit1 = empty, bits[7:4] = occupancy count, other bits 0.
  - 4 TX_DROPS (RW): saturating count of pushes lost because the FIFO was full; any write clears it to 0.
  - 5–7: reserved; read 0, writes ignored.
- Writes to RO registers are ignored.
- FIFO pop rule: pop when `tx_valid && tx_ready`.
- FIFO push rule: a TX_DATA write pushes when the FIFO is not full, or when it is full and a pop occurs in the same cycle. In that case the push is accepted and the count stays unchanged.
- Drop rule: a TX_DATA write that finds the FIFO full with no pop in that cycle is discarded and TX_DROPS increments, saturating at 32'hFFFF_FFFF.
- A TX_DROPS clear and a drop in the same cycle: the clear wins, so the result is 0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count ranges 0..`FIFO_DEPTH`.

## Timing
- `q_dmem` is registered.
  - In cycle N+1 it shows the read for the address presented in cycle N.
  - For RAM reads it passes `ram_q`, selected by a registered region flag.
  - For MMIO reads it shows register values sampled at the edge that ends cycle N. A CYCLE read therefore returns the counter value before that edge's increment.
- Store latency: the store takes effect at the edge ending the cycle in which `wren` is high. A load from the same MMIO register in the next cycle returns the new value.
- TX_STATUS read in the same cycle as a push or pop reports the state before that edge.
- `tx_valid` and `tx_data` follow from the FIFO state; the first pushed byte appears the cycle after its push.
- Reset (synchronous), applied at any time including mid-read or with the FIFO non-empty:
  - `q_dmem`, CYCLE, LED, TX_DROPS, FIFO pointers and count all go to 0.
  - `tx_valid` = 0.
  - In-flight read results are discarded.
  - RAM contents are untouched.
- `ram_wren` is never asserted for MMIO or unmapped addresses.

## Structure
- Package `dmem_mmio_pkg`: MMIO word offsets (`OFF_CYCLE`…`OFF_TX_DROPS`), TX_STATUS bit positions, and default `MMIO_BASE`.
- Sub-module `tx_fifo`: synchronous FIFO parameterised by depth and width, with push/pop/full/empty/count outputs and simultaneous push+pop allowed when full. The parent module owns the decode, the registers and the drop counter.

## Test plan
- Reset, then read MMIO+0 in two consecutive cycles → values differ by 1; `led` = 0 and `tx_valid` = 0 after reset.
- Write 32'h0001_ABCD to MMIO+1, then read MMIO+1 → `led` = 16'hABCD and `q_dmem` = 32'h0000_ABCD; `ram_wren` stays 0 throughout.
- Store 32'hDEAD_BEEF to address 5, then load address 5 → `ram_wren` = 1 with `ram_addr` = 5 during the store; `q_dmem` = 32'hDEAD_BEEF one cycle after the load address.
- Hold `tx_ready` = 0 and push 10 bytes → TX_STATUS = bit0 set with count 8, TX_DROPS = 2; raise `tx_ready` → the first 8 bytes drain in push order.
- FIFO full with `tx_ready` = 1 while pushing 8'h55 → push accepted, count stays 8, TX_DROPS unchanged, 8'h55 is the last byte out.
- Assert `reset` for one cycle with 3 bytes queued and a load in flight → the following cycle `tx_valid` = 0 and `q_dmem` = 0; reading unmapped address 32'h8000_0000 returns 0.
